// File: rtl/seg7_pkg.sv
// Segment glyph constants and hex decode helper for the scanned 7-segment display.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;   // {a,b,c,d,e,f,g}, active-high

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_0     = 7'h7E;
    localparam seg_t SEG_1     = 7'h30;
    localparam seg_t SEG_2     = 7'h6D;
    localparam seg_t SEG_3     = 7'h79;
    localparam seg_t SEG_4     = 7'h33;
    localparam seg_t SEG_5     = 7'h5B;
    localparam seg_t SEG_6     = 7'h5F;
    localparam seg_t SEG_7     = 7'h70;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h7B;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h1F;
    localparam seg_t SEG_C     = 7'h4E;
    localparam seg_t SEG_D     = 7'h3D;
    localparam seg_t SEG_E     = 7'h4F;
    localparam seg_t SEG_F     = 7'h47;

    // Map a hex nibble to its lit-segment pattern.
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder with blanking; output is active-high.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output seg_t       seg_c_o
);

    assign seg_c_o = blank_i ? SEG_BLANK : hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver: divider, digit scan, frame snapshot,
// leading-zero blanking, PWM brightness and polarity-adjusted output registers.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned DIV_LOG2       = 16,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic [NUM_DIGITS-1:0]     dp_in_i,
    input  logic [NUM_DIGITS-1:0]     blank_in_i,
    input  logic                      lzb_en_i,
    input  logic [3:0]                bright_i,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic [SEG_W-1:0]          seg_o,
    output logic                      dp_o,
    output logic                      frame_start_o
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_LOG2-1:0]   div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      value_snap_q, value_snap_d;
    logic [NUM_DIGITS-1:0] dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0] blank_snap_q, blank_snap_d;
    logic                  lzb_snap_q, lzb_snap_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q, frame_start_d;

    logic                  tick_c, wrap_c;
    logic [3:0]            nibble_c;
    logic                  dp_sel_c, blank_sel_c, zero_sel_c, zero_run_c;
    logic                  dark_c, pwm_on_c, dp_act_c;
    logic [NUM_DIGITS-1:0] an_act_c;
    seg_t                  seg_act_c;

    assign tick_c = &div_cnt_q;
    assign wrap_c = (idx_q == LAST_IDX);

    // Divider, digit index and end-of-frame snapshot capture.
    always_comb begin
        div_cnt_d     = div_cnt_q + DIV_LOG2'(1);
        idx_d         = idx_q;
        value_snap_d  = value_snap_q;
        dp_snap_d     = dp_snap_q;
        blank_snap_d  = blank_snap_q;
        lzb_snap_d    = lzb_snap_q;
        frame_start_d = tick_c & wrap_c;
        if (tick_c) begin
            if (wrap_c) begin
                idx_d        = '0;
                value_snap_d = value_i;
                dp_snap_d    = dp_in_i;
                blank_snap_d = blank_in_i;
                lzb_snap_d   = lzb_en_i;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Select the current digit's snapshot fields; zero_sel_c means all nibbles at or above idx are 0.
    always_comb begin
        nibble_c    = '0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b0;
        zero_sel_c  = 1'b0;
        zero_run_c  = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run_c = zero_run_c & (value_snap_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nibble_c    = value_snap_q[4*i +: 4];
                dp_sel_c    = dp_snap_q[i];
                blank_sel_c = blank_snap_q[i];
                zero_sel_c  = zero_run_c;
            end
        end
    end

    // Digit 0 is never leading-zero blanked so a zero value still shows "0".
    assign dark_c   = blank_sel_c | (lzb_snap_q & (idx_q != '0) & zero_sel_c);
    assign dp_act_c = dp_sel_c & ~dark_c;
    assign pwm_on_c = (div_cnt_q[DIV_LOG2-1 -: 4] <= bright_i);
    assign an_act_c = pwm_on_c ? (NUM_DIGITS'(1) << idx_q) : '0;

    seg7_decoder u_decoder (
        .nibble_i (nibble_c),
        .blank_i  (dark_c),
        .seg_c_o  (seg_act_c)
    );

    // Apply pin polarity at the output register inputs.
    always_comb begin
        an_d  = AN_ACTIVE_LOW  ? ~an_act_c  : an_act_c;
        seg_d = SEG_ACTIVE_LOW ? ~seg_act_c : seg_act_c;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_act_c  : dp_act_c;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            value_snap_q  <= '0;
            dp_snap_q     <= '0;
            blank_snap_q  <= '0;
            lzb_snap_q    <= 1'b0;
            an_q          <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg_q         <= {SEG_W{SEG_ACTIVE_LOW}};
            dp_q          <= SEG_ACTIVE_LOW;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            value_snap_q  <= value_snap_d;
            dp_snap_q     <= dp_snap_d;
            blank_snap_q  <= blank_snap_d;
            lzb_snap_q    <= lzb_snap_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an_o          = an_q;
    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign frame_start_o = frame_start_q;

endmodule
